seq_token_source: RTL and testbench

Clocked, parametrised successor to the self-timed ring sequence generators. It produces a stream of N-bit tokens from an internal sequence register (increment by STEP, bitwise invert, or Galois LFSR). Tokens are paced by a programmable gap counter that replaces the delay element, buffered in a DEPTH-entry FIFO, and delivered on a 4-phase bundled-data req/ack port. It sits at the boundary where a clocked Fomu domain feeds hlatch-based micropipelines.

---
 rtl/seq_pkg.sv | 18 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/seq_token_source.sv | 142 ++++++++++++++
 tb/tb_seq_token_source.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types for the clocked token source.
// Holds the sequence mode and handshake state encodings.
package seq_pkg;

  typedef enum logic [1:0] {
    SEQ_INC  = 2'd0,
    SEQ_INV  = 2'd1,
    SEQ_LFSR = 2'd2,
    SEQ_HOLD = 2'd3
  } seq_mode_e;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH-entry circular buffer, extra-bit pointers.
// Ports: push/push_data in, pop in, head (oldest entry), level.
module sync_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [N-1:0]                 push_data,
  input  logic                         pop,
  output logic [N-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  // Same index, different wrap bit: buffer is full.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign level = LW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/seq_token_source.sv
// seq_token_source: paced sequence generator feeding a 4-phase
// bundled-data port. Ports: clk, rst, en_i, mode_i, A_i in;
// R_o, D_o (token), level_o (FIFO occupancy) out.
module seq_token_source
  import seq_pkg::*;
#(
  parameter int           N     = 8,
  parameter int           DEPTH = 4,
  parameter int           GAP   = 2*N+2,
  parameter logic [N-1:0] STEP  = N'(1),
  parameter logic [N-1:0] INIT  = N'(1),
  parameter logic [N-1:0] TAPS  = N'(8'hB8),
  parameter int           SYNC  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [1:0]                 mode_i,
  input  logic                       A_i,
  output logic                       R_o,
  output logic [N-1:0]               D_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int GW = $clog2(GAP+2);

  seq_mode_e    mode;
  hs_state_e    state;
  logic [N-1:0] v;
  logic [N-1:0] v_next;
  logic [GW-1:0] gap_cnt;
  logic [N-1:0] head;
  logic         push;
  logic         pop;
  logic         a_s;

  assign mode = seq_mode_e'(mode_i);

  // Full is judged on registered level; a same-cycle pop
  // does not open a slot.
  assign push = en_i &&
                (level_o < LW'(DEPTH)) &&
                (gap_cnt == '0);

  always_comb begin
    v_next = v;
    unique case (1'b1)
      mode == SEQ_INC:  v_next = v + STEP;
      mode == SEQ_INV:  v_next = ~v;
      mode == SEQ_LFSR: v_next = (v >> 1) ^
                                 (v[0] ? TAPS : '0);
      mode == SEQ_HOLD: v_next = v;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      v <= INIT;
    else if (push)
      v <= v_next;
  end

  // Gap counter runs down independently of en_i.
  always_ff @(posedge clk) begin
    if (rst)
      gap_cnt <= '0;
    else if (push)
      gap_cnt <= GW'(GAP);
    else if (gap_cnt != '0)
      gap_cnt <= gap_cnt - GW'(1);
  end

  generate
    if (SYNC == 0) begin : g_nosync
      assign a_s = A_i;
    end else begin : g_sync
      logic [SYNC-1:0] sq;
      always_ff @(posedge clk) begin
        if (rst) begin
          sq <= '0;
        end else begin
          sq[0] <= A_i;
          for (int i = 1; i < SYNC; i++)
            sq[i] <= sq[i-1];
        end
      end
      assign a_s = sq[SYNC-1];
    end
  endgenerate

  // Head is consumed on the IDLE->REQ edge, so D_o only
  // moves when a new request is raised.
  assign pop = (state == HS_IDLE) &&
               (level_o != '0) && !a_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HS_IDLE;
      R_o   <= 1'b0;
      D_o   <= '0;
    end else begin
      unique case (state)
        HS_IDLE: begin
          if (pop) begin
            D_o   <= head;
            R_o   <= 1'b1;
            state <= HS_REQ;
          end
        end
        HS_REQ: begin
          if (a_s) begin
            R_o   <= 1'b0;
            state <= HS_RELEASE;
          end
        end
        HS_RELEASE: begin
          if (!a_s)
            state <= HS_IDLE;
        end
        default: begin
          R_o   <= 1'b0;
          state <= HS_IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (v),
    .pop       (pop),
    .head      (head),
    .level     (level_o)
  );

endmodule

// File: tb/tb_seq_token_source.sv
// tb_seq_token_source: scoreboard bench for seq_token_source.
// Three instances cover INC/LFSR/reset, STEP/INIT wrap, INV/pacing.
module tb_seq_token_source;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] A;
  logic [2:0] R;
  logic [7:0] D   [3];
  logic [2:0] lvl [3];

  int sel;
  int cyc;
  int total;
  int bad;
  int obs;
  bit ack_en;
  int rel_cyc;

  logic [7:0] exp_q [$];
  int         rise_q [$];

  seq_token_source #(
    .N(8), .DEPTH(4), .GAP(0), .STEP(8'd1),
    .INIT(8'h01), .TAPS(8'hB8), .SYNC(2)
  ) u0 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode),
    .A_i(A[0]), .R_o(R[0]), .D_o(D[0]), .level_o(lvl[0])
  );

  seq_token_source #(
    .N(8), .DEPTH(4), .GAP(0), .STEP(8'd3),
    .INIT(8'hFD), .TAPS(8'hB8), .SYNC(2)
  ) u1 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode),
    .A_i(A[1]), .R_o(R[1]), .D_o(D[1]), .level_o(lvl[1])
  );

  seq_token_source #(
    .N(8), .DEPTH(4), .GAP(18), .STEP(8'd1),
    .INIT(8'h0F), .TAPS(8'hB8), .SYNC(2)
  ) u2 (
    .clk(clk), .rst(rst), .en_i(en), .mode_i(mode),
    .A_i(A[2]), .R_o(R[2]), .D_o(D[2]), .level_o(lvl[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: ack one cycle after request, drop after release.
  initial begin
    A = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        A = '0;
      end else if (ack_en) begin
        if (R[sel] && !A[sel])
          A[sel] = 1'b1;
        else if (!R[sel] && A[sel])
          A[sel] = 1'b0;
      end
    end
  end

  // Monitor: every request rise pops one expected token.
  initial begin
    logic       pr;
    logic [7:0] e;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (R[sel] && !pr) begin
        rise_q.push_back(cyc);
        obs++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL token: unexpected D_o=%02h", D[sel]);
        end else begin
          e = exp_q.pop_front();
          if (D[sel] !== e) begin
            bad++;
            $display("FAIL token[%0d]: got %02h expected %02h",
                     obs, D[sel], e);
          end
        end
      end
      pr = R[sel];
    end
  end

  task automatic chk(input string name, input int got,
                     input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, got, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step(2);
    exp_q.delete();
    rise_q.delete();
    obs = 0;
  endtask

  task automatic release_rst();
    rst     = 1'b0;
    en      = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic load_inc(input logic [7:0] start,
                          input int n);
    logic [7:0] t;
    t = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(t);
      t = t + 8'd1;
    end
  endtask

  task automatic wait_obs(input string name, input int n,
                          input int limit);
    int k;
    k = 0;
    while (obs < n && k < limit) begin
      step(1);
      k++;
    end
    total++;
    if (obs < n) begin
      bad++;
      $display("FAIL %s timeout: tokens=%0d needed=%0d",
               name, obs, n);
    end
  endtask

  task automatic chk_first_rise(input string name);
    if (rise_q.size() > 0)
      chk(name, rise_q[0] - rel_cyc, 2);
    else
      chk(name, -1, 2);
  endtask

  initial begin
    int k;
    logic [7:0] lv [4];
    rst    = 1'b1;
    en     = 1'b0;
    mode   = 2'd0;
    sel    = 0;
    ack_en = 1'b0;
    total  = 0;
    bad    = 0;
    obs    = 0;
    step(1);

    // Reset state and INC with a responsive consumer.
    do_reset();
    chk("reset R_o", int'(R[0]), 0);
    chk("reset D_o", int'(D[0]), 0);
    chk("reset level_o", int'(lvl[0]), 0);
    mode   = 2'd0;
    ack_en = 1'b1;
    load_inc(8'h01, 40);
    release_rst();
    wait_obs("inc", 6, 200);
    chk_first_rise("first rise edge");

    // Stalled consumer: FIFO fills, one token held on D_o.
    do_reset();
    ack_en = 1'b0;
    load_inc(8'h01, 40);
    release_rst();
    step(20);
    chk("stall level_o", int'(lvl[0]), 4);
    chk("stall R_o", int'(R[0]), 1);
    chk("stall D_o", int'(D[0]), 1);
    step(10);
    chk("stall level_o hold", int'(lvl[0]), 4);
    ack_en = 1'b1;
    wait_obs("drain", 6, 200);

    // LFSR from 1.
    do_reset();
    mode = 2'd2;
    lv[0] = 8'h01;
    lv[1] = 8'hB8;
    lv[2] = 8'h5C;
    lv[3] = 8'h2E;
    for (int i = 0; i < 4; i++) exp_q.push_back(lv[i]);
    release_rst();
    wait_obs("lfsr", 4, 200);

    // Reset while R_o=1 with three tokens queued.
    do_reset();
    mode   = 2'd0;
    ack_en = 1'b0;
    load_inc(8'h01, 40);
    release_rst();
    k = 0;
    while (!(lvl[0] == 3'd3 && R[0]) && k < 20) begin
      step(1);
      k++;
    end
    chk("mid level before reset", int'(lvl[0]), 3);
    rst = 1'b1;
    step(1);
    chk("mid reset R_o", int'(R[0]), 0);
    chk("mid reset level_o", int'(lvl[0]), 0);
    chk("mid reset D_o", int'(D[0]), 0);
    do_reset();
    ack_en = 1'b1;
    load_inc(8'h01, 40);
    release_rst();
    wait_obs("restart", 3, 200);
    chk_first_rise("restart first rise");

    // STEP=3 from FD wraps through zero.
    do_reset();
    sel  = 1;
    mode = 2'd0;
    lv[0] = 8'hFD;
    lv[1] = 8'h00;
    lv[2] = 8'h03;
    lv[3] = 8'h06;
    for (int i = 0; i < 4; i++) exp_q.push_back(lv[i]);
    release_rst();
    wait_obs("step3", 4, 200);

    // INV from 0F with GAP=18 pacing.
    do_reset();
    sel  = 2;
    mode = 2'd1;
    lv[0] = 8'h0F;
    lv[1] = 8'hF0;
    lv[2] = 8'h0F;
    lv[3] = 8'hF0;
    for (int i = 0; i < 4; i++) exp_q.push_back(lv[i]);
    release_rst();
    wait_obs("inv gap", 4, 300);
    chk_first_rise("gap first rise");
    for (int i = 0; i < 3; i++) begin
      if (rise_q.size() > i + 1)
        chk("gap spacing", rise_q[i+1] - rise_q[i], 19);
      else
        chk("gap spacing", -1, 19);
    end

    en = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
